// File: rtl/code_dispatch_decoder.sv
// Event-code dispatch buffer: queues encoded event codes in order and replays
// each one as a registered one-hot strobe behind a show-ahead output register.
module code_dispatch_decoder #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CODE_W-1:0]        in_code,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [CODE_W-1:0]        out_code,
  output logic [(1<<CODE_W)-1:0]   out_onehot,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_proto
);

  localparam int OH_W  = 1 << CODE_W;
  localparam int ARR   = DEPTH - 1;
  localparam int PTR_W = (ARR > 1) ? $clog2(ARR) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef enum logic {EMPTY, LOADED} state_t;

  state_t            state, state_next;
  logic [CODE_W-1:0] mem [ARR];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  arr_count;
  logic [CODE_W-1:0] head_code;
  logic [CODE_W-1:0] stall_code;
  logic              push, pop, arr_empty;
  logic              load_head, bypass, arr_read, arr_write;
  logic              stall_q;

  // The array holds DEPTH-1 entries, so pointers wrap explicitly rather than by overflow.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ARR - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    arr_count = level - LVL_W'(out_valid);
    arr_empty = (arr_count == '0);
    head_code = bypass ? in_code : mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_head  = 1'b0;
    bypass     = 1'b0;
    arr_read   = 1'b0;
    arr_write  = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next = LOADED;
          load_head  = 1'b1;
          bypass     = 1'b1;
        end
      end
      LOADED: begin
        if (pop) begin
          if (!arr_empty) begin
            load_head = 1'b1;
            arr_read  = 1'b1;
            arr_write = push;
          end else if (push) begin
            load_head = 1'b1;
            bypass    = 1'b1;
          end else begin
            state_next = EMPTY;
          end
        end else begin
          arr_write = push;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // in_ready looks only at registered level, so backpressure never ripples combinationally.
  always_comb begin
    out_valid = (state == LOADED);
    in_ready  = (level != LVL_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (arr_write) mem[wr_ptr] <= in_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_code   <= '0;
      out_onehot <= '0;
      level      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_proto  <= 1'b0;
      stall_q    <= 1'b0;
      stall_code <= '0;
    end else begin
      if (load_head) begin
        out_code   <= head_code;
        out_onehot <= OH_W'(1) << head_code;
      end else if (pop) begin
        out_onehot <= '0;
      end
      if (arr_write) wr_ptr <= bump(wr_ptr);
      if (arr_read)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Held upstream data must stay put until taken; any withdrawal or change is latched.
      if (stall_q && (!in_valid || in_code != stall_code)) err_proto <= 1'b1;
      stall_q    <= in_valid && !in_ready;
      stall_code <= in_code;
    end
  end

endmodule

// File: tb/tb_code_dispatch_decoder.sv
// Directed self-checking bench for code_dispatch_decoder (CODE_W=2, DEPTH=4).
module tb_code_dispatch_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_code;
  logic [3:0] out_onehot;
  logic       out_ready;
  logic [2:0] level;
  logic       err_proto;

  int vectors = 0;
  int miscompares = 0;

  code_dispatch_decoder #(.CODE_W(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .out_valid(out_valid), .out_code(out_code), .out_onehot(out_onehot),
    .out_ready(out_ready), .level(level), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_code = 2'd0; out_ready = 1'b0;
    step(); step();
    vectors++;
    if ({out_valid, out_code, out_onehot, level, err_proto, in_ready} !== {1'b0, 2'd0, 4'b0000, 3'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got v=%b c=%0d oh=%b lvl=%0d err=%b rdy=%b, want v=0 c=0 oh=0000 lvl=0 err=0 rdy=1",
               out_valid, out_code, out_onehot, level, err_proto, in_ready);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_code = 2'd2; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, out_code, out_onehot, level} !== {1'b1, 2'd2, 4'b0100, 3'd1}) begin
      miscompares++;
      $display("[TB] FAIL single_load: got v=%b c=%0d oh=%b lvl=%0d, want v=1 c=2 oh=0100 lvl=1",
               out_valid, out_code, out_onehot, level);
    end
    step();
    vectors++;
    if ({out_valid, out_onehot, level} !== {1'b0, 4'b0000, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL single_drain: got v=%b oh=%b lvl=%0d, want v=0 oh=0000 lvl=0",
               out_valid, out_onehot, level);
    end
  endtask

  task automatic test_fill();
    logic [1:0] codes [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
    logic [3:0] exp_oh [5] = '{4'b0010, 4'b0001, 4'b0100, 4'b0010, 4'b0000};
    logic [2:0] exp_lvl [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_code = codes[i];
      step();
    end
    // Fifth code is held against a full buffer and must not be taken.
    in_code = 2'd1;
    vectors++;
    if ({level, in_ready, out_onehot} !== {3'd4, 1'b0, 4'b1000}) begin
      miscompares++;
      $display("[TB] FAIL fill_full: got lvl=%0d rdy=%b oh=%b, want lvl=4 rdy=0 oh=1000", level, in_ready, out_onehot);
    end
    step();
    vectors++;
    if ({level, in_ready} !== {3'd4, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL fill_hold: got lvl=%0d rdy=%b, want lvl=4 rdy=0", level, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) in_valid = 1'b0;
      vectors++;
      if (out_onehot !== exp_oh[i] || level !== exp_lvl[i]) begin
        miscompares++;
        $display("[TB] FAIL fill_drain_%0d: got oh=%b lvl=%0d, want oh=%b lvl=%0d",
                 i, out_onehot, level, exp_oh[i], exp_lvl[i]);
      end
      if (i == 0) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL fill_ready_rise: got rdy=%b, want 1", in_ready);
        end
      end
    end
    vectors++;
    if (err_proto !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill_no_err: got err=%b, want 0", err_proto);
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 2'd2; step();
    in_code = 2'd3; step();
    in_code = 2'd1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({level, out_onehot} !== {3'd2, 4'b1000}) begin
      miscompares++;
      $display("[TB] FAIL simul_pushpop: got lvl=%0d oh=%b, want lvl=2 oh=1000", level, out_onehot);
    end
    step();
    vectors++;
    if ({level, out_onehot} !== {3'd1, 4'b0010}) begin
      miscompares++;
      $display("[TB] FAIL simul_order: got lvl=%0d oh=%b, want lvl=1 oh=0010", level, out_onehot);
    end
    step();
    vectors++;
    if ({level, out_valid} !== {3'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL simul_empty: got lvl=%0d v=%b, want lvl=0 v=0", level, out_valid);
    end
  endtask

  task automatic test_wrap();
    int sent = 0, got = 0, cyc = 0, model_level = 0;
    logic acc, rel;
    while (got < 20 && cyc < 300) begin
      in_valid  = (sent < 20);
      in_code   = 2'(sent % 4);
      out_ready = (cyc % 2 == 0);
      #1;
      acc = in_valid && in_ready;
      rel = out_valid && out_ready;
      if (rel) begin
        vectors++;
        if (out_code !== 2'(got % 4) || out_onehot !== (4'b0001 << (got % 4))) begin
          miscompares++;
          $display("[TB] FAIL wrap_item_%0d: got c=%0d oh=%b, want c=%0d", got, out_code, out_onehot, got % 4);
        end
        got++;
      end
      if (acc) sent++;
      model_level = model_level + int'(acc) - int'(rel);
      step();
      cyc++;
      vectors++;
      if (level !== 3'(model_level) || model_level > 4) begin
        miscompares++;
        $display("[TB] FAIL wrap_level_c%0d: got lvl=%0d, want %0d", cyc, level, model_level);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (got != 20 || err_proto !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wrap_complete: got %0d items err=%b, want 20 items err=0", got, err_proto);
    end
  endtask

  task automatic test_proto();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_code = 2'(i);
      step();
    end
    in_code = 2'd1;
    step();
    vectors++;
    if (err_proto !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL proto_before: got err=%b, want 0", err_proto);
    end
    in_code = 2'd2;
    step();
    in_valid = 1'b0;
    vectors++;
    if (err_proto !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL proto_set: got err=%b, want 1", err_proto);
    end
    out_ready = 1'b1;
    repeat (6) step();
    vectors++;
    if ({err_proto, level} !== {1'b1, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL proto_sticky: got err=%b lvl=%0d, want err=1 lvl=0", err_proto, level);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_code = 2'(i);
      step();
    end
    vectors++;
    if ({level, out_onehot} !== {3'd3, 4'b0010}) begin
      miscompares++;
      $display("[TB] FAIL areset_pre: got lvl=%0d oh=%b, want lvl=3 oh=0010", level, out_onehot);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_code, out_onehot, level, err_proto} !== {1'b0, 2'd0, 4'b0000, 3'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL areset_async: got v=%b c=%0d oh=%b lvl=%0d err=%b, want all 0",
               out_valid, out_code, out_onehot, level, err_proto);
    end
    step();
    vectors++;
    if ({out_valid, level} !== {1'b0, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL areset_edge_drop: got v=%b lvl=%0d, want v=0 lvl=0", out_valid, level);
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    step();
    in_valid = 1'b1; in_code = 2'd3;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, out_onehot, level} !== {1'b1, 4'b1000, 3'd1}) begin
      miscompares++;
      $display("[TB] FAIL areset_first: got v=%b oh=%b lvl=%0d, want v=1 oh=1000 lvl=1",
               out_valid, out_onehot, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simultaneous();
    test_wrap();
    test_proto();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
